// File: rtl/fetch_unit_pkg.sv
// Instruction-bus request/response types shared by the fetch unit and its bench.
package fetch_unit_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one request outstanding on the instruction bus, a
// one-entry output buffer toward pre-decode, and redirect with response drop.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_REQ  | request presented (ireq.valid=1, addr=pc) unless buffer is
//        | full and decode is stalled
// S_WAIT | request accepted, waiting for data_ok (drop=1 discards it)
// S_HOLD | buffer full and stalled; a request goes out as soon as the
//        | stall releases, since the buffer drains on that same edge
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        drop_q;
    logic        drop_d;
    logic        out_valid_d;
    logic [31:0] out_pc_d;
    logic [31:0] out_instr_d;

    logic        consume;
    logic        issue;
    logic        accept;
    logic [31:0] target;

    // Instructions are word aligned; the low redirect bits carry no information.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Handshake qualifiers shared by the next-state logic and the bus outputs.
    always_comb begin
        consume = out_valid && !stall;
        // No new request while the buffer is full and cannot drain; a full
        // buffer that drains this cycle frees room for the returning word.
        issue   = (state_q == S_REQ || state_q == S_HOLD)
                  && !(out_valid && stall) && !reset;
        accept  = issue && iresp.addr_ok;
        target  = {redirect_pc[31:2], 2'b00};
    end

    // Instruction bus request: address is always the current pc.
    always_comb begin
        ireq       = '0;
        ireq.valid = issue;
        ireq.addr  = pc_q;
    end

    // Next-state, pc, drop flag and output buffer update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        out_valid_d = out_valid && !consume;
        out_pc_d    = out_pc;
        out_instr_d = out_instr;

        if (redirect_valid) begin
            // Redirect wins over everything and always flushes the buffer.
            pc_d        = target;
            out_valid_d = 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (iresp.data_ok) begin
                        // The outstanding response is here now; discard it.
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        // Stays set on a repeated redirect: only one
                        // response is ever in flight to be thrown away.
                        drop_d = 1'b1;
                    end
                end
                default: begin
                    if (accept && !iresp.data_ok) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end
                end
            endcase
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (iresp.data_ok) begin
                        state_d = S_REQ;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            out_valid_d = 1'b1;
                            out_pc_d    = pc_q;
                            out_instr_d = iresp.data;
                            pc_d        = pc_q + 32'd4;
                        end
                    end
                end
                default: begin
                    if (accept && iresp.data_ok) begin
                        // Zero-latency completion; the buffer is empty or
                        // draining this cycle, so keep requesting.
                        out_valid_d = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = iresp.data;
                        pc_d        = pc_q + 32'd4;
                        state_d     = S_REQ;
                    end else if (accept) begin
                        state_d = S_WAIT;
                    end else if (out_valid && stall) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            endcase
        end
    end

    // State and datapath registers; reset clears the buffer asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= 32'd0;
            out_instr <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            out_valid <= out_valid_d;
            out_pc    <= out_pc_d;
            out_instr <= out_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard queue and a latency-programmable bus model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    // bus model controls and state
    logic        bus_en;
    int          addr_lat;
    int          data_lat;
    logic        ovr_en;
    logic [31:0] ovr_data;
    int          wait_cnt;
    logic        pending;
    int          pend_lat;
    int          dcnt;
    logic [31:0] pend_data;
    logic        addr_ok_w;

    exp_t        exp_q[$];
    exp_t        e_m;
    int          total;
    int          bad;
    int          pulses;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bus responder: memory word at address a is ~a unless overridden
    always_comb begin
        addr_ok_w     = bus_en && ireq.valid && (wait_cnt >= addr_lat);
        iresp         = '0;
        iresp.addr_ok = addr_ok_w;
        iresp.data_ok = pending ? (dcnt >= pend_lat) : (addr_ok_w && data_lat == 0);
        iresp.data    = pending ? pend_data : ~ireq.addr;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= 1'b0;
            wait_cnt <= 0;
            dcnt     <= 0;
            pend_lat <= 0;
            pend_data <= 32'd0;
        end else begin
            if (addr_ok_w) begin
                wait_cnt <= 0;
                if (data_lat != 0) begin
                    pending   <= 1'b1;
                    dcnt      <= 1;
                    pend_lat  <= data_lat;
                    pend_data <= ovr_en ? ovr_data : ~ireq.addr;
                end
            end else if (bus_en && ireq.valid) begin
                wait_cnt <= wait_cnt + 1;
            end
            if (pending) begin
                if (iresp.data_ok) pending <= 1'b0;
                else dcnt <= dcnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic wait_ireq(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ireq.valid) seen = 1'b1;
        end
        chk("wait_ireq", {31'd0, seen}, 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    // scoreboard monitor: every consumed instruction must match the queue head
    always @(negedge clk) begin
        if (!reset && out_valid && !stall) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got pc %h instr %h required none", out_pc, out_instr);
            end else begin
                e_m = exp_q.pop_front();
                chk("out_pc", out_pc, e_m.pc);
                chk("out_instr", out_instr, e_m.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; pulses = 0;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        bus_en = 1'b0; addr_lat = 0; data_lat = 0; ovr_en = 1'b0; ovr_data = 32'd0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ireq_valid", {31'd0, ireq.valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);

        // zero-latency bus: one instruction per cycle
        push(32'hbfc0_0000, 32'h403f_ffff);
        push(32'hbfc0_0004, 32'h403f_fffb);
        push(32'hbfc0_0008, 32'h403f_fff7);
        reset = 1'b0; bus_en = 1'b1;
        @(negedge clk);
        chk("first_valid", {31'd0, ireq.valid}, 32'd1);
        chk("first_addr", ireq.addr, 32'hbfc0_0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            if (i == 2) begin
                #1 bus_en = 1'b0;
            end
            @(negedge clk);
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_pc", out_pc, 32'hbfc0_0000 + 32'(4 * i));
        end
        drain(10);

        // slow bus: addr_ok after 3 waiting cycles, data_ok 2 cycles later
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        addr_lat = 3; data_lat = 2; bus_en = 1'b1;
        push(32'hbfc0_0000, 32'h403f_ffff);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("slow_valid", {31'd0, ireq.valid}, 32'd1);
            chk("slow_addr", ireq.addr, 32'hbfc0_0000);
        end
        @(negedge clk);
        chk("slow_wait_valid", {31'd0, ireq.valid}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                bus_en = 1'b0;
            end
        end
        chk("slow_pulses", pulses, 32'd1);
        drain(5);

        // stall with a full buffer for 5 cycles
        @(posedge clk); #1;
        addr_lat = 0; data_lat = 0;
        push(32'hbfc0_0004, 32'h403f_fffb);
        push(32'hbfc0_0008, 32'h403f_fff7);
        bus_en = 1'b1;
        @(posedge clk); #1;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pc", out_pc, 32'hbfc0_0004);
            chk("hold_instr", out_instr, 32'h403f_fffb);
            chk("hold_ireq", {31'd0, ireq.valid}, 32'd0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        chk("release_ireq", {31'd0, ireq.valid}, 32'd1);
        chk("release_addr", ireq.addr, 32'hbfc0_0008);
        @(posedge clk); #1;
        bus_en = 1'b0;
        drain(10);

        // redirect while waiting: dead_beef response must be discarded
        @(posedge clk); #1;
        addr_lat = 0; data_lat = 3; ovr_en = 1'b1; ovr_data = 32'hdead_beef;
        bus_en = 1'b1;
        @(posedge clk); #1;
        bus_en = 1'b0; ovr_en = 1'b0; data_lat = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        wait_ireq(10);
        chk("drop_addr", ireq.addr, 32'h8000_0100);
        chk("drop_no_out", {31'd0, out_valid}, 32'd0);
        push(32'h8000_0100, 32'h7fff_feff);
        bus_en = 1'b1;
        @(posedge clk); #1;
        bus_en = 1'b0;
        drain(10);

        // redirect coincident with data_ok: no drop of the next response
        @(posedge clk); #1;
        addr_lat = 0; data_lat = 2; bus_en = 1'b1;
        @(posedge clk); #1;
        bus_en = 1'b0;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("coinc_valid", {31'd0, ireq.valid}, 32'd1);
        chk("coinc_addr", ireq.addr, 32'h8000_0200);
        push(32'h8000_0200, 32'h7fff_fdff);
        bus_en = 1'b1;
        @(posedge clk); #1;
        bus_en = 1'b0;
        drain(10);

        // reset during HOLD clears the buffer immediately
        @(posedge clk); #1;
        addr_lat = 0; data_lat = 0; bus_en = 1'b1;
        @(posedge clk); #1;
        bus_en = 1'b0; stall = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_ireq", {31'd0, ireq.valid}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_ireq", {31'd0, ireq.valid}, 32'd0);
        chk("async_out_pc", out_pc, 32'd0);
        chk("async_out_instr", out_instr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, ireq.valid}, 32'd1);
        chk("post_rst_addr", ireq.addr, 32'hbfc0_0000);
        chk("final_queue", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc0_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-004 ireq  output  ibus_req_t  SHALL carry valid and addr[31:0] to the instruction bus.
REQ-005 iresp  input  ibus_resp_t  SHALL carry addr_ok, data_ok and data[31:0] from the instruction bus.
REQ-006 redirect_valid  input  1  SHALL request a PC change (branch/jump resolved downstream).
REQ-007 redirect_pc  input  32  SHALL be the new fetch target; bits [1:0] ignored, forced to 0.
REQ-008 stall  input  1  SHALL indicate the decode stage cannot accept an instruction this cycle.
REQ-009 out_valid  output  1  SHALL flag a valid fetched instruction for pre-decode.
REQ-010 out_pc  output  32  SHALL be the address of out_instr.
REQ-011 out_instr  output  32  SHALL be the raw instruction word returned by iresp.data.

Function
REQ-012 States SHALL be REQ (ireq.valid=1, addr=pc), WAIT (request accepted, awaiting data_ok), HOLD (buffer full, stalled); at most one request outstanding.
REQ-013 REQ: on addr_ok without data_ok -> WAIT; on addr_ok with data_ok same cycle -> treated as completion per REQ-015; without addr_ok -> stay REQ, addr stable unless redirected.
REQ-014 WAIT: ireq.valid=0; stay until data_ok.
REQ-015 Completion (data_ok, drop=0): load out_pc=pc, out_instr=iresp.data, out_valid=1; pc<=pc+4 (mod 2^32, wrap from ffff_fffc to 0); next state REQ if buffer is consumed this cycle or empty, else HOLD.
REQ-016 One-entry output buffer: out_valid stays 1 with out_pc/out_instr stable while stall=1; consumed on any cycle with out_valid=1 and stall=0.
REQ-017 New request SHALL NOT be issued while buffer is full and stall=1 (HOLD: ireq.valid=0); HOLD -> REQ on the consuming cycle.
REQ-018 Best-case throughput SHALL be one instruction per cycle when addr_ok and data_ok return in the cycle of request and stall=0.
REQ-019 Redirect has priority over all other events; on redirect_valid=1: pc<=redirect_pc, out_valid<=0 next cycle (buffer flushed, even if stall=1).
REQ-020 Redirect in REQ without addr_ok: stay REQ, next-cycle addr=redirect_pc.
REQ-021 Redirect in REQ with addr_ok but no data_ok, or in WAIT without data_ok: set drop=1, go/stay WAIT.
REQ-022 WAIT with drop=1 on data_ok: discard data, clear drop, out_valid unchanged (0), go REQ at current pc.
REQ-023 Redirect coincident with data_ok (REQ or WAIT): data discarded, drop stays 0, next state REQ at redirect_pc.
REQ-024 Redirect in HOLD: buffer flushed, next state REQ at redirect_pc.
REQ-025 A second redirect while drop=1 SHALL only update pc; drop remains 1; exactly one response discarded.

Reset
REQ-026 While reset=1: state=REQ, pc=RESET_PC, drop=0, out_valid=0, out_pc=0, out_instr=0; ireq.valid SHALL be 0 during reset.
REQ-027 First cycle after reset deassertion SHALL drive ireq.valid=1, ireq.addr=RESET_PC.
REQ-028 Reset asserted mid-WAIT SHALL abandon the outstanding request; its later data_ok (if any, after bus reset) is not required to be handled.

Verification
REQ-029 Zero-latency bus (addr_ok=data_ok=1 each request), stall=0 -> out_pc bfc0_0000, bfc0_0004, bfc0_0008 on consecutive cycles, data matches.
REQ-030 addr_ok delayed 3 cycles, data_ok 2 cycles after -> ireq.addr held bfc0_0000 for 4 cycles, one out_valid pulse with correct data.
REQ-031 stall=1 for 5 cycles with buffer full -> out_valid=1, out_pc/out_instr stable, ireq.valid=0; stall release -> next fetch at pc+4 issued same cycle.
REQ-032 Redirect to 8000_0100 while WAIT -> pending response (data dead_beef) discarded, no out_valid for it; next request addr 8000_0100.
REQ-033 Redirect to 8000_0203 coincident with data_ok -> data discarded, next addr 8000_0200, no drop of the following response.
REQ-034 Reset asserted during HOLD -> out_valid=0 immediately (async), after release ireq.addr=bfc0_0000.
